// File: rtl/game_ctrl_if.sv
// Whack-a-mole controller bus: game inputs from buttons/timer and the
// controller's outputs toward the display and countdown timer.
interface game_ctrl_if;
  logic       start;
  logic [3:0] whack;
  logic       gameend;
  logic       gamestart;
  logic [5:0] gametime;
  logic [3:0] mole;
  logic [7:0] score;
  logic [1:0] state;

  modport master (
    output start, whack, gameend,
    input  gamestart, gametime, mole, score, state
  );

  modport slave (
    input  start, whack, gameend,
    output gamestart, gametime, mole, score, state
  );
endinterface

// File: rtl/game_ctrl.sv
// Whack-a-mole game controller: alternates a mole-free gap with a random
// mole phase, counts hits and stops when the countdown timer expires.
module game_ctrl #(
  parameter int GAME_SECONDS = 30,
  parameter int GAP_CYCLES   = 25_000_000,
  parameter int MOLE_CYCLES  = 75_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  game_ctrl_if.slave  io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [26:0] GAP_LAST  = 27'(GAP_CYCLES - 1);
  localparam logic [26:0] MOLE_LAST = 27'(MOLE_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [26:0] r_cnt, w_cnt_next;
  logic [7:0]  r_lfsr, w_lfsr_next;
  logic [7:0]  r_score, w_score_next;
  logic [3:0]  r_mole, w_mole_next;
  logic [1:0]  r_prev, w_prev_next;
  logic [1:0]  w_idx;
  logic        r_gamestart;
  logic        w_hit;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; primitive, so a nonzero seed never hits zero
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_idx       = (r_lfsr[1:0] == r_prev) ? r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];
  assign w_hit       = |(io.whack & r_mole);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_score_next = r_score;
    w_mole_next  = r_mole;
    w_prev_next  = r_prev;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (io.start) begin
          w_state_next = S_GAP;
          w_cnt_next   = '0;
          w_score_next = '0;
          w_mole_next  = '0;
        end
      end
      S_GAP: begin
        if (io.gameend) begin
          w_state_next = S_OVER;
          w_cnt_next   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_next = S_UP;
          w_cnt_next   = '0;
          w_mole_next  = 4'b0001 << w_idx;
          w_prev_next  = w_idx;
        end else begin
          w_cnt_next = r_cnt + 27'd1;
        end
      end
      S_UP: begin
        // gameend wins over a hit; a hit wins over the timeout
        if (io.gameend) begin
          w_state_next = S_OVER;
          w_cnt_next   = '0;
          w_mole_next  = '0;
        end else if (w_hit) begin
          w_state_next = S_GAP;
          w_cnt_next   = '0;
          w_mole_next  = '0;
          w_score_next = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
        end else if (r_cnt == MOLE_LAST) begin
          w_state_next = S_GAP;
          w_cnt_next   = '0;
          w_mole_next  = '0;
        end else begin
          w_cnt_next = r_cnt + 27'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_mole_next  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lfsr      <= 8'hA5;
      r_score     <= '0;
      r_mole      <= '0;
      r_prev      <= '0;
      r_gamestart <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_lfsr      <= w_lfsr_next;
      r_score     <= w_score_next;
      r_mole      <= w_mole_next;
      r_prev      <= w_prev_next;
      r_gamestart <= (w_state_next == S_GAP) || (w_state_next == S_UP);
    end
  end

  assign io.state     = r_state;
  assign io.mole      = r_mole;
  assign io.score     = r_score;
  assign io.gamestart = r_gamestart;
  assign io.gametime  = 6'(GAME_SECONDS);

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized and directed checks of game_ctrl against a phase/timer model
// built from the game rules.
module tb_game_ctrl;
  localparam int G    = 4;
  localparam int M    = 10;
  localparam int SECS = 30;
  localparam int P_IDLE = 0, P_GAP = 1, P_UP = 2, P_OVER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_if bus ();

  game_ctrl #(
    .GAME_SECONDS(SECS),
    .GAP_CYCLES  (G),
    .MOLE_CYCLES (M)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (rst),
    .io       (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int up_entries = 0;

  // model: phase plus remaining cycles in that phase
  int         m_phase = P_IDLE;
  int         m_rem   = 0;
  int         m_score = 0;
  int         m_prev  = 0;
  logic [3:0] m_mole  = 4'd0;
  logic [7:0] m_lfsr  = 8'hA5;
  logic [3:0] last_dut_mole = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_step(input logic s, input logic [3:0] w, input logic ge, input logic r);
    int idx;
    if (r) begin
      m_phase = P_IDLE; m_rem = 0; m_score = 0; m_prev = 0;
      m_mole = 4'd0; m_lfsr = 8'hA5;
      return;
    end
    case (m_phase)
      P_IDLE, P_OVER: if (s) begin
        m_phase = P_GAP; m_rem = G; m_score = 0; m_mole = 4'd0;
      end
      P_GAP: begin
        if (ge) m_phase = P_OVER;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            idx = int'(m_lfsr[1:0]);
            if (idx == m_prev) idx = (idx + 1) % 4;
            m_prev = idx;
            m_mole = 4'(1 << idx);
            m_phase = P_UP; m_rem = M;
          end
        end
      end
      default: begin
        if (ge) begin
          m_phase = P_OVER; m_mole = 4'd0;
        end else if ((w & m_mole) != 4'd0) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_phase = P_GAP; m_rem = G; m_mole = 4'd0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = P_GAP; m_rem = G; m_mole = 4'd0;
          end
        end
      end
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic tick(input logic s, input logic [3:0] w, input logic ge, input logic r);
    int prev_phase;
    prev_phase = m_phase;
    bus.start = s; bus.whack = w; bus.gameend = ge; rst = r;
    @(posedge clk);
    model_step(s, w, ge, r);
    @(negedge clk);
    chk("state", 32'(bus.state), 32'(m_phase));
    chk("mole", 32'(bus.mole), 32'(m_mole));
    chk("score", 32'(bus.score), 32'(m_score));
    chk("gamestart", 32'(bus.gamestart), 32'((m_phase == P_GAP) || (m_phase == P_UP)));
    chk("gametime", 32'(bus.gametime), 32'(SECS));
    if (prev_phase == P_GAP && m_phase == P_UP) begin
      if (up_entries > 0) chk("norepeat", 32'(bus.mole == last_dut_mole), 32'd0);
      chk("onehot", 32'($countones(bus.mole)), 32'd1);
      last_dut_mole = bus.mole;
      up_entries++;
    end
    if (r) up_entries = 0;
    bus.start = 1'b0; bus.whack = 4'd0; bus.gameend = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_up();
    int n = 0;
    while (m_phase != P_UP && n < 60) begin
      tick(1'b0, 4'd0, 1'b0, 1'b0);
      n++;
    end
    if (m_phase != P_UP) chk("reach_up", 32'(bus.state), 32'(P_UP));
  endtask

  initial begin
    bus.start = 1'b0; bus.whack = 4'd0; bus.gameend = 1'b0;

    tick(1'b0, 4'd0, 1'b0, 1'b1);        // reset state
    tick(1'b1, 4'd0, 1'b0, 1'b0);        // start -> GAP
    wait_up();
    tick(1'b0, m_mole, 1'b0, 1'b0);      // hit -> score 1
    wait_up();
    tick(1'b0, ~m_mole, 1'b0, 1'b0);     // wrong holes ignored
    tick(1'b1, 4'd0, 1'b0, 1'b0);        // start ignored in UP
    idle(M + 2);                         // timeout back to GAP
    wait_up();
    idle(M - 1);
    tick(1'b0, m_mole, 1'b0, 1'b0);      // hit on the timeout cycle
    wait_up();
    tick(1'b0, m_mole, 1'b1, 1'b0);      // gameend beats hit
    idle(2);
    tick(1'b0, 4'd0, 1'b1, 1'b0);        // gameend ignored in OVER
    tick(1'b1, 4'd0, 1'b0, 1'b0);        // restart clears score

    for (int i = 0; i < 262; i++) begin  // saturate score, >200 UP entries
      wait_up();
      tick(1'b0, m_mole | 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end

    tick(1'b0, 4'd0, 1'b0, 1'b1);
    tick(1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      wait_up();
      tick(1'b0, m_mole, 1'b0, 1'b0);
    end
    wait_up();
    tick(1'b0, m_mole, 1'b0, 1'b1);      // reset mid-game with score 7

    for (int i = 0; i < 4000; i++) begin
      logic       s, ge, r;
      logic [3:0] w;
      s  = ($urandom_range(0, 29) == 0);
      ge = ($urandom_range(0, 149) == 0);
      r  = ($urandom_range(0, 799) == 0);
      if (m_phase == P_UP && $urandom_range(0, 3) == 0) w = m_mole | 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) w = 4'($urandom_range(0, 15));
      else w = 4'd0;
      tick(s, w, ge, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter GAME_SECONDS, default 30: game length in seconds, driven on gametime.
REQ-002 Parameter GAP_CYCLES, default 25_000_000: clock cycles with no mole between moles.
REQ-003 Parameter MOLE_CYCLES, default 75_000_000: maximum clock cycles a mole stays up.
REQ-004 CLK100MHZ  in  1  system clock, 100 MHz; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  debounced single-cycle start pulse.
REQ-007 whack  in  4  debounced single-cycle hole button pulses, bit i = hole i.
REQ-008 gameend  in  1  end flag from the countdown timer.
REQ-009 gamestart  out  1  run enable to the countdown timer.
REQ-010 gametime  out  6  game length to the countdown timer, constant GAME_SECONDS.
REQ-011 mole  out  4  one-hot active mole, 0 = none.
REQ-012 score  out  8  hits this game.
REQ-013 state  out  2  FSM state: 0 IDLE, 1 GAP, 2 UP, 3 OVER.

Function
REQ-014 FSM states SHALL be IDLE, GAP, UP, OVER; all outputs registered.
REQ-015 gamestart SHALL be 1 exactly when state is GAP or UP.
REQ-016 IDLE: start=1 -> GAP, score cleared to 0, cycle counter cleared to 0.
REQ-017 OVER: start=1 -> GAP, score cleared to 0, cycle counter cleared to 0; otherwise hold, score retained.
REQ-018 Start pulses in GAP or UP SHALL be ignored.
REQ-019 Cycle counter: 27 bits, cleared on every state entry, +1 per cycle in GAP and UP.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then enter UP.
REQ-021 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, SHALL step every cycle; reset seed 8'hA5; never all-zero.
REQ-022 On GAP->UP: idx = lfsr[1:0]; if idx equals the previous mole index, idx = (idx+1) mod 4; mole = 1<<idx, valid on first UP cycle.
REQ-023 Previous mole index SHALL reset to 0 and update on each UP entry.
REQ-024 UP: (whack & mole) != 0 -> score +1, saturating at 255; -> GAP next cycle; mole = 0.
REQ-025 UP: whack bits not matching mole SHALL be ignored (no penalty, no state change).
REQ-026 UP: no hit within MOLE_CYCLES cycles -> GAP, mole = 0, score unchanged.
REQ-027 gameend=1 in GAP or UP -> OVER next cycle, mole = 0; takes precedence over a hit in the same cycle (hit not scored).
REQ-028 gameend SHALL be ignored in IDLE and OVER (the countdown timer clears it while gamestart=0).
REQ-029 Hit and mole timeout in the same cycle SHALL count as a hit.

Reset
REQ-030 reset=1 SHALL force, on the next edge: state=IDLE, gamestart=0, mole=0, score=0, counter=0, LFSR=8'hA5, previous index=0.
REQ-031 reset SHALL take precedence over all inputs, including mid-game; gametime stays GAME_SECONDS.

Verification (GAP_CYCLES=4, MOLE_CYCLES=10)
REQ-032 Reset, then start pulse -> state=1 and gamestart=1 next cycle; mole=0 for 4 cycles; then state=2 and mole one-hot.
REQ-033 In UP, pulse whack equal to mole -> score=1, state=1, mole=0 next cycle; 20 hits -> score=20.
REQ-034 In UP, no whack for 10 cycles -> state=1, score unchanged; wrong-hole whack -> no change.
REQ-035 Hit and gameend in the same cycle -> state=3, score unchanged, gamestart=0, mole=0; then start -> state=1, score=0.
REQ-036 Force score=255, then hit -> score stays 255; 200 consecutive UP entries -> mole never repeats consecutively.
REQ-037 reset asserted in UP with score=7 -> next cycle state=0, mole=0, score=0, gamestart=0.
